// File: rtl/telemetry_snapshot_bank.sv
// Coherent multi-channel snapshot capture into a frame FIFO.
// Frames stream out as one header (sequence number) followed by NUM_CH channel words.
module telemetry_snapshot_bank #(
  parameter int NUM_CH = 22,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
  input  logic                       capture_i,
  input  logic                       enable_i,
  input  logic [15:0]                decim_i,
  input  logic                       clear_i,
  output logic [DATA_W-1:0]          m_data_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic                       m_first_o,
  output logic                       m_last_o,
  output logic [$clog2(DEPTH):0]     fill_o,
  output logic                       overflow_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);
  // state  | meaning
  // IDLE   | no frame stored, stream idle
  // HEADER | presenting sequence number of the head frame
  // CHAN   | presenting channel word idx of the head frame
  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [FW-1:0] DEPTH_F  = FW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, HEADER, CHAN} state_t;

  logic [DATA_W-1:0] frame_mem [DEPTH][NUM_CH];
  logic [DATA_W-1:0] seq_mem   [DEPTH];

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_n;
  logic [FW-1:0]     fill_n;
  logic [DATA_W-1:0] frame_seq;
  logic [15:0]       dec_cnt, dec_cnt_n, dec_cur, dec_eff;
  logic              strobe, req, push, drop, pop, hs;
  logic [DATA_W-1:0] data_n;
  logic              valid_n, first_n, last_n;

  // A shrunken decim_i that no longer covers dec_cnt wraps the counter at once.
  always_comb begin
    strobe    = capture_i & enable_i;
    dec_eff   = (decim_i > 16'd1) ? decim_i : 16'd1;
    dec_cur   = (dec_cnt >= dec_eff) ? 16'd0 : dec_cnt;
    req       = strobe && (dec_cur == 16'd0);
    dec_cnt_n = dec_cur;
    if (strobe) dec_cnt_n = (dec_cur == dec_eff - 16'd1) ? 16'd0 : dec_cur + 16'd1;
  end

  always_comb begin
    hs       = m_valid_o & m_ready_i;
    pop      = hs && (state == CHAN) && (idx == LAST_IDX);
    push     = req && ((fill_o != DEPTH_F) || pop);
    drop     = req && !push;
    fill_n   = fill_o + FW'(push) - FW'(pop);
    rd_ptr_n = pop ? rd_ptr + PW'(1) : rd_ptr;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE:   if (fill_o != '0) state_n = HEADER;
      HEADER: if (hs) begin
                state_n = CHAN;
                idx_n   = '0;
              end
      CHAN:   if (hs) begin
                if (idx == LAST_IDX) state_n = (fill_n != '0) ? HEADER : IDLE;
                else                 idx_n   = idx + IW'(1);
              end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are precomputed from next state; a header following a pop may
  // belong to the frame being written this very edge, so bypass its seq.
  always_comb begin
    valid_n = (state_n != IDLE);
    first_n = (state_n == HEADER);
    last_n  = (state_n == CHAN) && (idx_n == LAST_IDX);
    data_n  = '0;
    if (state_n == HEADER)
      data_n = (push && (wr_ptr == rd_ptr_n)) ? frame_seq : seq_mem[rd_ptr_n];
    else if (state_n == CHAN)
      data_n = frame_mem[rd_ptr_n][idx_n];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < NUM_CH; k++) frame_mem[wr_ptr][k] <= ch_data_i[k*DATA_W +: DATA_W];
      seq_mem[wr_ptr] <= frame_seq;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      idx        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_o     <= '0;
      frame_seq  <= '0;
      dec_cnt    <= '0;
      m_data_o   <= '0;
      m_valid_o  <= 1'b0;
      m_first_o  <= 1'b0;
      m_last_o   <= 1'b0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      rd_ptr    <= rd_ptr_n;
      fill_o    <= fill_n;
      dec_cnt   <= dec_cnt_n;
      m_data_o  <= data_n;
      m_valid_o <= valid_n;
      m_first_o <= first_n;
      m_last_o  <= last_n;
      if (push) begin
        wr_ptr    <= wr_ptr + PW'(1);
        frame_seq <= frame_seq + DATA_W'(1);
      end
      if (clear_i) begin
        overflow_o <= drop;
        drop_cnt_o <= DROP_W'(drop);
      end else if (drop) begin
        overflow_o <= 1'b1;
        if (!(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
      end
    end
  end
endmodule
